float_class_arbiter: RTL and testbench
======================================

Name: float_class_arbiter

Overview:
- Shares one combinational single-precision classifier (the team's FloatType unit) between NREQ requesters.
- Arbitration is round-robin, with a valid/ready handshake on every requester port and on the response port.
- Results sit in a one-entry output register, tagged with the requester ID and the sign.
- Per-class saturating statistics counters sit alongside; the block lives in front of the FP exception/trap logic.

Parameters:
- NREQ, 2, number of requesters (2..4).
- IDW, 2, requester-ID width (must satisfy 2**IDW >= NREQ).
- CNTW, 16, width of each statistics counter.

Ports:
- clk  in  1  rising-edge clock, single clock domain.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  NREQ  per-requester request valid.
- req_num  in  32*NREQ  IEEE-754 single operands; requester i occupies bits [32*i+31:32*i].
- req_ready  out  NREQ  per-requester accept, one-hot or zero.
- resp_valid  out  1  response register holds a result.
- resp_ready  in  1  consumer accepts the response.
- resp_id  out  IDW  requester index of the held result.
- resp_type  out  5  one-hot class: [0] zero, [1] normal, [2] subnormal, [3] infinity, [4] NaN.
- resp_sign  out  1  sign bit of the classified operand.
- stat_clr  in  1  synchronous clear of all counters.
- cnt_zero, cnt_norm, cnt_sub, cnt_inf, cnt_nan  out  CNTW each  accepted-operand count per class.

Behaviour:
- Reset:
  - resp_valid=0, resp_id=0, resp_type=0, resp_sign=0.
  - All counters 0, round-robin pointer rr=0.
  - req_ready is forced to 0 in the reset cycle.
- Classification, on the exponent e and mantissa m of the operand:
  - zero: e=0, m=0.
  - subnormal: e=0, m!=0.
  - infinity: e=0xFF, m=0.
  - NaN: e=0xFF, m!=0.
  - normal: anything else.
  - Sign does not affect the class; +0 and -0 are both zero.
- Output register state machine, two states:
  - EMPTY (resp_valid=0).
  - FULL (resp_valid=1).
  - can_accept = EMPTY, or FULL with resp_ready=1.
- Arbitration (combinational):
  - grant = the first i with req_valid[i]=1, searching from index rr upward modulo NREQ.
  - req_ready = onehot(grant) & can_accept; all zero when no request is valid.
  - req_ready must not depend on resp_ready when the register is EMPTY.
- Accept (req_valid[g] && req_ready[g]):
  - Next cycle the register loads resp_type/resp_sign/resp_id from requester g; resp_valid=1.
  - rr <= (g+1) mod NREQ.
  - Latency from accept to resp_valid is exactly 1 cycle.
- Drain without accept (FULL, resp_ready=1, no accept): goes to EMPTY next cycle; resp_valid=0; resp_* hold their last values.
- Simultaneous drain and accept: stays FULL with the new result, giving 1 result/cycle throughput and no bubble.
- Stall (FULL, resp_ready=0):
  - All req_ready=0; resp_* held stable; rr unchanged.
  - A requester's valid may remain asserted indefinitely without loss.
- rr advances only on an accept, never on an idle cycle.
- Counters:
  - On each accept, the counter for the granted class increments by 1.
  - Saturates at 2**CNTW-1; no wrap.
  - stat_clr=1 forces all counters to 0 in that cycle. This overrides a same-cycle increment: the result is 0, not 1.
- Reset mid-transaction: a held response is discarded (resp_valid=0 next cycle). No req_ready is given in the reset cycle, so no request is accepted.
- Undefined/X on req_num for non-granted requesters has no effect.

Decomposition:
- Shared package fp_pkg:
  - Class-index localparams CLS_ZERO=0, CLS_NORM=1, CLS_SUB=2, CLS_INF=3, CLS_NAN=4.
  - EXP_MAX=8'hFF.
  - Field slice widths (EXP_W=8, MAN_W=23).
- Sub-module: one instance of the existing FloatType classifier (num in, float_type out), fed by the granted operand mux.
- Round-robin find-first stays inline; no second sub-module.

Test Plan:
- Reset, then single request: req_valid=01, req_num[0]=32'h3FC00000 -> req_ready=01 in the same cycle; the next cycle gives resp_valid=1, resp_id=0, resp_type=5'b00010, resp_sign=0, cnt_norm=1.
- Class sweep on requester 1, resp_ready=1, back-to-back:
  - 00000000 -> 00001 (zero).
  - 80000000 -> 00001, resp_sign=1.
  - 002AAAA8 -> 00100 (subnormal).
  - 7F800000 -> 01000 (infinity).
  - 7FAAAAA8 -> 10000 (NaN).
  - Final counters: zero=2, sub=1, inf=1, nan=1; one response per cycle.
- Fairness: both valid continuously, resp_ready=1 -> resp_id sequence 0,1,0,1,... for 8 cycles, starting at 0 after reset.
- Backpressure: resp_ready=0 for 3 cycles while FULL with a requester valid -> req_ready=0, resp_* stable. Raising resp_ready -> drain and new accept in the same cycle, resp_valid stays 1.
- Saturation/clear:
  - With CNTW=4, 17 zero operands -> cnt_zero=15.
  - stat_clr together with an accept -> cnt_zero=0.
- Reset while FULL -> resp_valid=0 next cycle; rr=0; counters 0; the next grant goes to requester 0 when both are valid.

Source files
------------

// File: rtl/fp_pkg.sv
// Shared floating-point classification constants and the arbiter's output-register state type.
package fp_pkg;

    localparam int EXP_W = 8;
    localparam int MAN_W = 23;
    localparam int NCLS  = 5;

    localparam int CLS_ZERO = 0;
    localparam int CLS_NORM = 1;
    localparam int CLS_SUB  = 2;
    localparam int CLS_INF  = 3;
    localparam int CLS_NAN  = 4;

    localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } out_state_e;

    function automatic logic [NCLS-1:0] cls_onehot(input int idx);
        return NCLS'(1) << idx;
    endfunction

endpackage

// File: rtl/FloatType.sv
// Combinational IEEE-754 single-precision classifier: one-hot class plus the sign bit.
module FloatType
    import fp_pkg::*;
(
    input  logic [31:0]     num,
    output logic [NCLS-1:0] float_type,
    output logic            sign
);

    logic [EXP_W-1:0] exp_s;
    logic [MAN_W-1:0] man_s;

    assign sign  = num[31];
    assign exp_s = num[30:23];
    assign man_s = num[22:0];

    // Class decode from exponent/mantissa; sign never affects the class.
    always_comb begin
        float_type = cls_onehot(CLS_NORM);
        if (exp_s == {EXP_W{1'b0}}) begin
            if (man_s == {MAN_W{1'b0}}) float_type = cls_onehot(CLS_ZERO);
            else                        float_type = cls_onehot(CLS_SUB);
        end else if (exp_s == EXP_MAX) begin
            if (man_s == {MAN_W{1'b0}}) float_type = cls_onehot(CLS_INF);
            else                        float_type = cls_onehot(CLS_NAN);
        end else begin
            float_type = cls_onehot(CLS_NORM);
        end
    end

endmodule

// File: rtl/float_class_arbiter.sv
// Round-robin arbiter sharing one FloatType classifier between NREQ requesters,
// with a one-entry response register and saturating per-class statistics.
module float_class_arbiter
    import fp_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int IDW  = 2,
    parameter int CNTW = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [32*NREQ-1:0]   req_num,
    output logic [NREQ-1:0]      req_ready,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [IDW-1:0]       resp_id,
    output logic [NCLS-1:0]      resp_type,
    output logic                 resp_sign,
    input  logic                 stat_clr,
    output logic [CNTW-1:0]      cnt_zero,
    output logic [CNTW-1:0]      cnt_norm,
    output logic [CNTW-1:0]      cnt_sub,
    output logic [CNTW-1:0]      cnt_inf,
    output logic [CNTW-1:0]      cnt_nan
);

    out_state_e          state_q;
    logic [IDW-1:0]      rr_q, rr_d;
    logic [IDW-1:0]      resp_id_q;
    logic [NCLS-1:0]     resp_type_q;
    logic                resp_sign_q;
    logic [CNTW-1:0]     cnt_q [NCLS];
    logic [CNTW-1:0]     cnt_d [NCLS];

    logic [IDW-1:0]      grant_s;
    logic                any_s;
    logic                can_accept_s;
    logic                accept_s;
    logic [31:0]         num_s;
    logic [NCLS-1:0]     type_s;
    logic                sign_s;

    // Find-first valid requester starting at rr, wrapping modulo NREQ.
    always_comb begin
        int pos;
        grant_s = {IDW{1'b0}};
        any_s   = 1'b0;
        pos     = 0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            pos = int'(rr_q) + k;
            if (pos >= NREQ) pos = pos - NREQ;
            else             pos = pos;
            for (int i = 0; i < NREQ; i++) begin
                if ((i == pos) && req_valid[i]) begin
                    grant_s = IDW'(i);
                    any_s   = 1'b1;
                end else begin
                    grant_s = grant_s;
                end
            end
        end
    end

    // An EMPTY register accepts regardless of resp_ready; reset blocks every grant.
    assign can_accept_s = (state_q == ST_EMPTY) || resp_ready;
    assign accept_s     = any_s && can_accept_s && !reset;
    assign rr_d         = (grant_s == IDW'(NREQ - 1)) ? {IDW{1'b0}} : grant_s + IDW'(1);

    // One-hot ready for the granted port and operand mux feeding the classifier.
    always_comb begin
        num_s = 32'h0000_0000;
        for (int i = 0; i < NREQ; i++) begin
            req_ready[i] = accept_s && (grant_s == IDW'(i));
            if (grant_s == IDW'(i)) num_s = req_num[32*i +: 32];
            else                    num_s = num_s;
        end
    end

    FloatType u_float_type (
        .num        (num_s),
        .float_type (type_s),
        .sign       (sign_s)
    );

    // Output-register FSM: load on accept, drain to EMPTY when consumed with nothing new.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_EMPTY;
            rr_q        <= {IDW{1'b0}};
            resp_id_q   <= {IDW{1'b0}};
            resp_type_q <= {NCLS{1'b0}};
            resp_sign_q <= 1'b0;
        end else begin
            case (state_q)
                ST_EMPTY, ST_FULL: begin
                    if (accept_s) begin
                        state_q     <= ST_FULL;
                        rr_q        <= rr_d;
                        resp_id_q   <= grant_s;
                        resp_type_q <= type_s;
                        resp_sign_q <= sign_s;
                    end else if (resp_ready) begin
                        state_q <= ST_EMPTY;
                    end else begin
                        state_q <= state_q;
                    end
                end
                default: state_q <= ST_EMPTY;
            endcase
        end
    end

    // Saturating class counters; a clear wins over a same-cycle increment.
    always_comb begin
        for (int c = 0; c < NCLS; c++) begin
            if (stat_clr)
                cnt_d[c] = {CNTW{1'b0}};
            else if (accept_s && type_s[c] && (cnt_q[c] != {CNTW{1'b1}}))
                cnt_d[c] = cnt_q[c] + CNTW'(1);
            else
                cnt_d[c] = cnt_q[c];
        end
    end

    // Counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int c = 0; c < NCLS; c++) cnt_q[c] <= {CNTW{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign resp_valid = (state_q == ST_FULL);
    assign resp_id    = resp_id_q;
    assign resp_type  = resp_type_q;
    assign resp_sign  = resp_sign_q;
    assign cnt_zero   = cnt_q[CLS_ZERO];
    assign cnt_norm   = cnt_q[CLS_NORM];
    assign cnt_sub    = cnt_q[CLS_SUB];
    assign cnt_inf    = cnt_q[CLS_INF];
    assign cnt_nan    = cnt_q[CLS_NAN];

endmodule

// File: tb/tb_float_class_arbiter.sv
// Scoreboard bench for float_class_arbiter: a reference model predicts grants and results,
// and a monitor checks every presented response against the expected queue.
module tb_float_class_arbiter;

    localparam int NREQ = 2;
    localparam int IDW  = 2;
    localparam int CNTW = 4;
    localparam int CMAX = 15;

    logic                clk = 1'b0;
    logic                reset;
    logic [NREQ-1:0]     req_valid;
    logic [32*NREQ-1:0]  req_num;
    logic [NREQ-1:0]     req_ready;
    logic                resp_valid;
    logic                resp_ready;
    logic [IDW-1:0]      resp_id;
    logic [4:0]          resp_type;
    logic                resp_sign;
    logic                stat_clr;
    logic [CNTW-1:0]     cnt_zero, cnt_norm, cnt_sub, cnt_inf, cnt_nan;

    always #5 clk = ~clk;

    float_class_arbiter #(.NREQ(NREQ), .IDW(IDW), .CNTW(CNTW)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_num    (req_num),
        .req_ready  (req_ready),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_id    (resp_id),
        .resp_type  (resp_type),
        .resp_sign  (resp_sign),
        .stat_clr   (stat_clr),
        .cnt_zero   (cnt_zero),
        .cnt_norm   (cnt_norm),
        .cnt_sub    (cnt_sub),
        .cnt_inf    (cnt_inf),
        .cnt_nan    (cnt_nan)
    );

    int n_pass  = 0;
    int n_total = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endfunction

    typedef struct packed {
        logic [IDW-1:0] id;
        logic [4:0]     ty;
        logic           sg;
    } resp_t;

    resp_t exp_q[$];

    // Class index straight from the IEEE-754 field rules.
    function automatic int ref_class(input logic [31:0] x);
        int e, m;
        e = int'(x[30:23]);
        m = int'(x[22:0]);
        if (e == 0)   return (m == 0) ? 0 : 2;
        if (e == 255) return (m == 0) ? 3 : 4;
        return 1;
    endfunction

    // Reference model state.
    int    m_rr = 0;
    bit    m_full = 1'b0;
    int    m_cnt [5] = '{0, 0, 0, 0, 0};
    int    m_g, m_ci;
    bit    m_can;
    logic [31:0] m_x, m_rdy;
    resp_t m_r;

    // Model: evaluated mid-cycle once inputs are stable; predicts ready, response and counters.
    always @(negedge clk) begin
        #1;
        chk("resp_valid", 32'(resp_valid), 32'(m_full));
        chk("cnt_zero", 32'(cnt_zero), 32'(m_cnt[0]));
        chk("cnt_norm", 32'(cnt_norm), 32'(m_cnt[1]));
        chk("cnt_sub",  32'(cnt_sub),  32'(m_cnt[2]));
        chk("cnt_inf",  32'(cnt_inf),  32'(m_cnt[3]));
        chk("cnt_nan",  32'(cnt_nan),  32'(m_cnt[4]));
        if (reset) begin
            chk("ready_in_reset", 32'(req_ready), 32'd0);
            exp_q.delete();
            m_full = 1'b0;
            m_rr   = 0;
            for (int c = 0; c < 5; c++) m_cnt[c] = 0;
        end else begin
            m_g = -1;
            for (int k = 0; k < NREQ; k++)
                if (m_g < 0 && req_valid[(m_rr + k) % NREQ]) m_g = (m_rr + k) % NREQ;
            m_can = !m_full || resp_ready;
            m_rdy = (m_g >= 0 && m_can) ? (32'd1 << m_g) : 32'd0;
            chk("req_ready", 32'(req_ready), m_rdy);
            if (m_g >= 0 && m_can) begin
                m_x   = req_num[32*m_g +: 32];
                m_ci  = ref_class(m_x);
                m_r.id = IDW'(m_g);
                m_r.ty = 5'(1 << m_ci);
                m_r.sg = m_x[31];
                exp_q.push_back(m_r);
                m_rr   = (m_g + 1) % NREQ;
                m_full = 1'b1;
                if (m_cnt[m_ci] < CMAX) m_cnt[m_ci]++;
            end else if (resp_ready) begin
                m_full = 1'b0;
            end
            if (stat_clr) for (int c = 0; c < 5; c++) m_cnt[c] = 0;
        end
    end

    // Monitor: every presented response must match the queue head; pop on transfer.
    always @(negedge clk) begin
        if (resp_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_resp", 32'd1, 32'd0);
            end else begin
                chk("resp_id",   32'(resp_id),   32'(exp_q[0].id));
                chk("resp_type", 32'(resp_type), 32'(exp_q[0].ty));
                chk("resp_sign", 32'(resp_sign), 32'(exp_q[0].sg));
                if (resp_ready) void'(exp_q.pop_front());
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] pick_num();
        logic [31:0] tbl [8];
        tbl = '{32'h0000_0000, 32'h8000_0000, 32'h002A_AAA8, 32'h7F80_0000,
                32'hFF80_0000, 32'h7FAA_AAA8, 32'h3FC0_0000, 32'h0080_0000};
        if ($urandom_range(0, 1) == 0) return tbl[$urandom_range(0, 7)];
        return $urandom;
    endfunction

    logic [31:0] sweep_num [5];
    logic [4:0]  sweep_ty  [5];
    logic        sweep_sg  [5];

    initial begin
        sweep_num = '{32'h0000_0000, 32'h8000_0000, 32'h002A_AAA8, 32'h7F80_0000, 32'h7FAA_AAA8};
        sweep_ty  = '{5'b00001, 5'b00001, 5'b00100, 5'b01000, 5'b10000};
        sweep_sg  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

        reset = 1'b1; req_valid = '0; req_num = '0; resp_ready = 1'b0; stat_clr = 1'b0;
        cyc(); cyc();

        // Single request after reset.
        reset = 1'b0; req_valid = 2'b01; req_num[31:0] = 32'h3FC0_0000; resp_ready = 1'b1;
        cyc();
        chk("t1_valid", 32'(resp_valid), 32'd1);
        chk("t1_id",    32'(resp_id),    32'd0);
        chk("t1_type",  32'(resp_type),  32'h02);
        chk("t1_sign",  32'(resp_sign),  32'd0);
        chk("t1_norm",  32'(cnt_norm),   32'd1);
        req_valid = 2'b00;
        cyc();

        // Class sweep on requester 1, back-to-back.
        req_valid = 2'b10;
        for (int i = 0; i < 5; i++) begin
            req_num[63:32] = sweep_num[i];
            cyc();
            chk("sweep_valid", 32'(resp_valid), 32'd1);
            chk("sweep_type",  32'(resp_type),  32'(sweep_ty[i]));
            chk("sweep_sign",  32'(resp_sign),  32'(sweep_sg[i]));
        end
        req_valid = 2'b00;
        cyc();
        chk("sweep_zero", 32'(cnt_zero), 32'd2);
        chk("sweep_sub",  32'(cnt_sub),  32'd1);
        chk("sweep_inf",  32'(cnt_inf),  32'd1);
        chk("sweep_nan",  32'(cnt_nan),  32'd1);

        // Fairness from reset.
        reset = 1'b1; cyc();
        reset = 1'b0; req_valid = 2'b11;
        req_num = {32'h4000_0000, 32'h3F80_0000};
        for (int i = 0; i < 8; i++) begin
            cyc();
            chk("fair_id", 32'(resp_id), 32'(i % 2));
        end

        // Backpressure then simultaneous drain and accept.
        req_valid = 2'b01; resp_ready = 1'b0; req_num[31:0] = 32'h3F80_0000;
        cyc();
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("bp_ready", 32'(req_ready), 32'd0);
            chk("bp_valid", 32'(resp_valid), 32'd1);
        end
        resp_ready = 1'b1; req_num[31:0] = 32'h7F80_0000;
        cyc();
        chk("bp_drain_valid", 32'(resp_valid), 32'd1);
        chk("bp_drain_type",  32'(resp_type),  32'h08);

        // Saturation and clear-with-accept.
        reset = 1'b1; req_valid = 2'b00; cyc();
        reset = 1'b0; req_valid = 2'b01; req_num[31:0] = 32'h0000_0000;
        repeat (17) cyc();
        req_valid = 2'b00; cyc();
        chk("sat_zero", 32'(cnt_zero), 32'd15);
        stat_clr = 1'b1; req_valid = 2'b01;
        cyc();
        stat_clr = 1'b0; req_valid = 2'b00;
        chk("clr_zero", 32'(cnt_zero), 32'd0);
        cyc();

        // Reset while FULL.
        req_valid = 2'b01; req_num[31:0] = 32'h4000_0000; resp_ready = 1'b0;
        cyc();
        reset = 1'b1; req_valid = 2'b11;
        cyc();
        chk("rst_valid", 32'(resp_valid), 32'd0);
        chk("rst_norm",  32'(cnt_norm),   32'd0);
        reset = 1'b0; resp_ready = 1'b1;
        cyc();
        chk("rst_grant", 32'(resp_id), 32'd0);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            reset      = ($urandom_range(0, 63) == 0);
            req_valid  = NREQ'($urandom_range(0, 3));
            req_num    = {pick_num(), pick_num()};
            resp_ready = ($urandom_range(0, 3) != 0);
            stat_clr   = ($urandom_range(0, 31) == 0);
            cyc();
        end

        reset = 1'b0; req_valid = '0; resp_ready = 1'b1; stat_clr = 1'b0;
        repeat (3) cyc();
        chk("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
